spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: turns opcode/address/data bytes from an SPI slave into
// single register read/write handshakes and streams read data back out.
module spi_cmd_ctrl #(
  parameter int TIMEOUT    = 255,
  parameter int DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tx_byte,
  output logic        tx_load,
  output logic        reg_req,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic        reg_ack,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, OPC, ADDR, WDATA, WREQ, RREQ, RDATA, ERR} state_t;

  state_t      state;
  logic        cs_q;
  logic        abort;    // frame ended while a handshake was outstanding
  logic        ovr;      // master clocked a byte before read data was ready
  logic [2:0]  bcnt;
  logic [7:0]  tcnt;
  logic [31:0] rdata_q;

  assign busy = (state != IDLE) || reg_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cs_q      <= 1'b0;
      abort     <= 1'b0;
      ovr       <= 1'b0;
      bcnt      <= '0;
      tcnt      <= '0;
      rdata_q   <= '0;
      tx_byte   <= '0;
      tx_load   <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      err       <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      cs_q    <= cs_active;
      case (state)
        IDLE: if (cs_active && !cs_q) begin
          state   <= OPC;
          err     <= 1'b0;
          tx_byte <= {err, busy, 6'b010101};
          tx_load <= 1'b1;
          abort   <= 1'b0;
          ovr     <= 1'b0;
        end
        OPC: if (!cs_active) state <= IDLE;
          else if (rx_valid) begin
            if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
              reg_we <= (rx_byte == 8'h01);
              state  <= ADDR;
            end else if (rx_byte == 8'h00) begin
              tx_byte <= {err, busy, 6'b010101};
              tx_load <= 1'b1;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        ADDR: if (!cs_active) state <= IDLE;
          else if (rx_valid) begin
            reg_addr <= rx_byte;
            bcnt     <= '0;
            if (reg_we) state <= WDATA;
            else begin
              state   <= RREQ;
              reg_req <= 1'b1;
              tcnt    <= '0;
            end
          end
        WDATA: if (!cs_active) state <= IDLE;
          else if (rx_valid) begin
            reg_wdata <= {reg_wdata[23:0], rx_byte};
            bcnt      <= bcnt + 3'd1;
            if (bcnt == 3'(DATA_BYTES - 1)) begin
              state   <= WREQ;
              reg_req <= 1'b1;
              tcnt    <= '0;
            end
          end
        WREQ, RREQ: begin
          if (reg_req && reg_ack) begin
            reg_req <= 1'b0;
            if (abort || !cs_active) state <= IDLE;
            else if (state == WREQ) state <= OPC;
            else if (ovr || rx_valid) begin
              err   <= 1'b1;
              state <= ERR;
            end else begin
              rdata_q <= reg_rdata << 8;
              tx_byte <= reg_rdata[31:24];
              tx_load <= 1'b1;
              bcnt    <= '0;
              state   <= RDATA;
            end
          end else if (tcnt == 8'(TIMEOUT - 1)) begin
            reg_req <= 1'b0;
            err     <= 1'b1;
            state   <= (abort || !cs_active) ? IDLE : ERR;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (!cs_active) abort <= 1'b1;
            if (state == RREQ && rx_valid && cs_active) ovr <= 1'b1;
          end
        end
        RDATA: if (!cs_active) state <= IDLE;
          else if (rx_valid) begin
            if (bcnt == 3'(DATA_BYTES - 1)) state <= OPC;
            else begin
              tx_byte <= rdata_q[31:24];
              rdata_q <= rdata_q << 8;
              tx_load <= 1'b1;
              bcnt    <= bcnt + 3'd1;
            end
          end
        ERR: if (!cs_active) state <= IDLE;
          else if (rx_valid) begin
            tx_byte <= 8'hEE;
            tx_load <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a vector table for the byte-level protocol
// plus hand sequences for handshakes, timeout, aborts and async reset.
module tb_spi_cmd_ctrl;
  logic        clk = 1'b0;
  logic        reset_n, cs_active, rx_valid, reg_ack;
  logic [7:0]  rx_byte, tx_byte, reg_addr;
  logic        tx_load, reg_req, reg_we, busy, err;
  logic [31:0] reg_wdata, reg_rdata;

  int pass = 0, total = 0, req_rises = 0;

  spi_cmd_ctrl #(.TIMEOUT(255), .DATA_BYTES(4)) dut (
    .clk(clk), .reset_n(reset_n), .cs_active(cs_active), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .tx_load(tx_load), .reg_req(reg_req),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack),
    .reg_rdata(reg_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge reg_req) req_rises++;

  typedef struct {
    logic       cs;
    logic       rxv;
    logic [7:0] rxb;
    logic [7:0] tx;
    logic       ld;
    logic       bsy;
    logic       er;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    cs_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_frame();
    cs_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt, r0;
    logic [7:0] rd_exp[3];
    rd_exp[0] = 8'h34; rd_exp[1] = 8'h56; rd_exp[2] = 8'h78;

    // cs, rxv, rxb, expected tx_byte, tx_load, busy, err
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h15, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h00, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h7F, 8'h55, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'hAA, 8'hEE, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'hEE, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'h55, 8'hEE, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'hEE, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'hEE, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h95, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h00, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h7F, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; cs_active = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    reg_ack = 1'b0; reg_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {tx_byte, tx_load, reg_req, reg_we, reg_addr, reg_wdata, busy, err}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      cs_active = tbl[i].cs; rx_valid = tbl[i].rxv; rx_byte = tbl[i].rxb;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {tx_byte, tx_load, busy, err, reg_req},
          {tbl[i].tx, tbl[i].ld, tbl[i].bsy, tbl[i].er, 1'b0});
    end
    rx_valid = 1'b0;

    // write 01 10 DE AD BE EF, ack three clocks after request
    r0 = req_rises;
    start_frame();
    send(8'h01); send(8'h10); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("wr_req", {reg_req, reg_we, reg_addr, reg_wdata}, {1'b1, 1'b1, 8'h10, 32'hDEADBEEF});
    repeat (2) @(negedge clk);
    chk("wr_req_held", {reg_req, reg_we, reg_addr, reg_wdata}, {1'b1, 1'b1, 8'h10, 32'hDEADBEEF});
    reg_ack = 1'b1; @(negedge clk); reg_ack = 1'b0;
    chk("wr_done", {reg_req, busy, err}, {1'b0, 1'b1, 1'b0});
    chk("wr_req_count", 64'(req_rises - r0), 64'd1);
    send(8'h00);
    chk("wr_back_in_opc", {tx_load, tx_byte}, {1'b1, 8'h55});
    end_frame();

    // read 02 22, data 12345678
    start_frame();
    send(8'h02); send(8'h22);
    chk("rd_req", {reg_req, reg_we, reg_addr}, {1'b1, 1'b0, 8'h22});
    reg_ack = 1'b1; reg_rdata = 32'h12345678;
    @(negedge clk);
    reg_ack = 1'b0; reg_rdata = '0;
    chk("rd_byte0", {tx_load, tx_byte, reg_req}, {1'b1, 8'h12, 1'b0});
    @(negedge clk);
    chk("rd_load_width", tx_load, 1'b0);
    for (int k = 0; k < 3; k++) begin
      send(8'hFF);
      chk($sformatf("rd_byte%0d", k + 1), {tx_load, tx_byte}, {1'b1, rd_exp[k]});
    end
    send(8'hFF);
    chk("rd_last_dummy", tx_load, 1'b0);
    send(8'h00);
    chk("rd_back_in_opc", {tx_load, tx_byte}, {1'b1, 8'h55});
    end_frame();

    // write with no ack: timeout after 255 clocks
    start_frame();
    send(8'h01); send(8'h10); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    cnt = 0;
    while (reg_req && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_len", 64'(cnt), 64'd255);
    chk("timeout_state", {reg_req, err, busy}, {1'b0, 1'b1, 1'b1});
    send(8'h33);
    chk("timeout_err_byte", {tx_load, tx_byte}, {1'b1, 8'hEE});
    end_frame();
    chk("err_sticky", {err, busy}, {1'b1, 1'b0});

    // partial write then cs drop
    start_frame();
    chk("status_after_err", {tx_load, tx_byte, err}, {1'b1, 8'h95, 1'b0});
    r0 = req_rises;
    send(8'h01); send(8'h10); send(8'hDE); send(8'hAD);
    cs_active = 1'b0;
    @(negedge clk);
    chk("partial_wr_idle", {busy, reg_req}, {1'b0, 1'b0});
    chk("partial_wr_noreq", 64'(req_rises - r0), 64'd0);

    // read with cs falling while the request is outstanding
    start_frame();
    send(8'h02); send(8'h22);
    cs_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_abort_held", {reg_req, busy}, {1'b1, 1'b1});
    reg_ack = 1'b1; reg_rdata = 32'hCAFEF00D;
    @(negedge clk);
    reg_ack = 1'b0;
    chk("rd_abort_idle", {reg_req, busy, tx_load}, {1'b0, 1'b0, 1'b0});
    @(negedge clk);

    // read overrun: dummy byte arrives before ack
    start_frame();
    send(8'h02); send(8'h22); send(8'h55);
    reg_ack = 1'b1; @(negedge clk); reg_ack = 1'b0;
    chk("overrun_err", {reg_req, err, busy, tx_load}, {1'b0, 1'b1, 1'b1, 1'b0});
    send(8'h11);
    chk("overrun_err_byte", {tx_load, tx_byte}, {1'b1, 8'hEE});
    end_frame();

    // async reset while a request is pending
    start_frame();
    send(8'h02); send(8'h22);
    chk("pre_reset_req", reg_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_reset", {reg_req, tx_load, tx_byte, reg_we, reg_addr, reg_wdata, busy, err}, '0);
    cs_active = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
